sram_port0_ctrl: RTL and testbench

- Initiator for a single-port 1RW SRAM macro port (csb0/web0/addr0/din0/dout0, inputs registered on posedge, read data valid before the next posedge).
- Converts a valid/ready request stream (read or write) into SRAM port cycles, one per clock.
- Tracks in-flight reads and returns read data in order through a show-ahead response FIFO with valid/ready backpressure.
- Sits between the bus/agent logic and the SRAM macro.

---
 rtl/sram_port0_ctrl.sv | 107 ++++++++++
 tb/tb_sram_port0_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port0_ctrl.sv
// Request/response front end for one 1RW SRAM macro port.
// Credit-limited issue, fixed-latency read capture, in-order show-ahead FIFO.
module sram_port0_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LAT     = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  busy
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  logic [RD_LAT-1:0]     r_vld;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];

  logic [CW-1:0] w_inflight;
  logic [CW:0]   w_used;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_vld[i]);
    end
  end

  // Credit counts reads still in the pipe, so a landing read always has a slot.
  assign w_used    = {1'b0, r_count} + {1'b0, w_inflight};
  assign req_ready = !rst0 && (w_used < (CW + 1)'(RSP_DEPTH));
  assign w_acc     = req_valid && req_ready;
  assign w_push    = r_vld[RD_LAT-1];
  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_rdata = r_mem[r_rptr];
  assign busy      = (w_inflight != '0) || rsp_valid;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      csb0  <= 1'b1;
      web0  <= 1'b1;
      addr0 <= '0;
      din0  <= '0;
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[RD_LAT-2:0], w_acc & ~req_we};
      if (w_acc) begin
        csb0  <= 1'b0;
        web0  <= ~req_we;
        addr0 <= req_addr;
        if (req_we) din0 <= req_wdata;
      end else begin
        csb0 <= 1'b1;
        web0 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= dout0;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_ovf: assert property (@(posedge clk0) disable iff (rst0)
    !(w_push && !w_pop && r_count == CW'(RSP_DEPTH)));
  a_no_udf: assert property (@(posedge clk0) disable iff (rst0)
    !(w_pop && r_count == '0));

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl with a behavioural 1RW SRAM macro.
// Read data is scoreboarded against a shadow memory of accepted writes.
module tb_sram_port0_ctrl;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;
  logic          busy;

  sram_port0_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(2), .RSP_DEPTH(4)
  ) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .busy(busy)
  );

  always #5 clk0 = ~clk0;

  logic          m_csb = 1'b1;
  logic          m_web = 1'b1;
  logic [AW-1:0] m_a   = '0;
  logic [DW-1:0] m_d   = '0;
  logic [DW-1:0] m_mem [512];
  logic [DW-1:0] shadow [512];

  // Macro: latch on posedge, act on negedge, garbage after hold time.
  always begin
    @(posedge clk0);
    m_csb = csb0;
    m_web = web0;
    m_a   = addr0;
    m_d   = din0;
    #1 dout0 = 32'hA5A5_5A5A;
    @(negedge clk0);
    if (!m_csb) begin
      if (!m_web) m_mem[m_a] = m_d;
      else        dout0 = m_mem[m_a];
    end
  end

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  // Handshakes are stable from negedge to the next posedge.
  always @(negedge clk0) begin
    if (!rst0) begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rsp_unexp", 64'd1, 64'd0);
        else chk("rsp_data", 64'(rsp_rdata), 64'(q.pop_front()));
      end
      if (req_valid && req_ready) begin
        if (req_we) shadow[req_addr] = req_wdata;
        else        q.push_back(shadow[req_addr]);
      end
    end
  end

  int acc;
  logic rdy;

  initial begin
    for (int i = 0; i < 512; i++) begin
      m_mem[i]  = '0;
      shadow[i] = '0;
    end
    rst0 = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    repeat (3) step();
    chk("rst_rdy", 64'(req_ready), 64'd0);
    rst0 = 1'b0;
    #1;
    chk("rst_csb", 64'(csb0), 64'd1);
    chk("rst_web", 64'(web0), 64'd1);
    chk("rst_addr", 64'(addr0), 64'd0);
    chk("rst_din", 64'(din0), 64'd0);
    chk("rst_vld", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready1", 64'(req_ready), 64'd1);

    issue(1'b1, 9'h1A5, 32'hDEADBEEF);
    chk("wr_csb", 64'(csb0), 64'd0);
    chk("wr_web", 64'(web0), 64'd0);
    chk("wr_addr", 64'(addr0), 64'h1A5);
    chk("wr_din", 64'(din0), 64'hDEADBEEF);
    issue(1'b0, 9'h1A5, 32'h0);
    chk("rd_csb", 64'(csb0), 64'd0);
    chk("rd_web", 64'(web0), 64'd1);
    chk("rd_din", 64'(din0), 64'hDEADBEEF);
    chk("rd_busy", 64'(busy), 64'd1);
    req_valid = 1'b0;
    step();
    chk("idle_csb", 64'(csb0), 64'd1);
    chk("rd_early", 64'(rsp_valid), 64'd0);
    step();
    chk("rd_vld", 64'(rsp_valid), 64'd1);
    chk("rd_head", 64'(rsp_rdata), 64'hDEADBEEF);
    step();
    chk("rd_done", 64'(rsp_valid), 64'd0);
    chk("rd_busy0", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 32'h01010101 * i);
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = AW'(k);
      chk("strm_rdy", 64'(req_ready), 64'd1);
      step();
      chk("strm_vld", 64'(rsp_valid), 64'(k >= 2));
    end
    req_valid = 1'b0;
    step();
    chk("strm_tail0", 64'(rsp_valid), 64'd1);
    step();
    chk("strm_tail1", 64'(rsp_valid), 64'd1);
    step();
    chk("strm_end", 64'(rsp_valid), 64'd0);
    drain();

    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = AW'(acc + 3);
      rdy = req_ready;
      step();
      if (rdy) acc++;
    end
    req_valid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'd4);
    chk("bp_rdy0", 64'(req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_vld", 64'(rsp_valid), 64'd1);
      chk("bp_stable", 64'(rsp_rdata), 64'(q[0]));
      step();
    end
    rsp_ready = 1'b1;
    chk("bp_rdy_pop", 64'(req_ready), 64'd0);
    step();
    chk("bp_rdy_next", 64'(req_ready), 64'd1);
    drain();

    issue(1'b0, 9'h010, 32'h0);
    req_valid = 1'b0;
    rst0 = 1'b1;
    q.delete();
    #1;
    chk("mr_csb", 64'(csb0), 64'd1);
    chk("mr_rdy", 64'(req_ready), 64'd0);
    step();
    step();
    rst0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mr_vld", 64'(rsp_valid), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
    end

    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, AW'(4 + i), 32'h0);
    req_valid = 1'b0;
    step();
    chk("ff_rdy", 64'(req_ready), 64'd0);
    chk("ff_vld", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    step();
    chk("ff_keep", 64'(rsp_valid), 64'd1);
    chk("ff_rdy1", 64'(req_ready), 64'd1);
    step();
    chk("ff_c2", 64'(rsp_valid), 64'd1);
    step();
    chk("ff_c1", 64'(rsp_valid), 64'd1);
    step();
    chk("ff_c0", 64'(rsp_valid), 64'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
